// File: rtl/dp_ram_param.sv
// Simple dual-port RAM with byte-enable writes, selectable read-during-write policy,
// optional output register and a self-clearing init sweep. Out-of-range accesses raise err.
module dp_ram_param #(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 10,
   parameter int DEPTH          = 1024,
   parameter int RDW_MODE       = 0,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    wr,
   input  logic [ADDR_WIDTH-1:0]   write_adr,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd,
   input  logic [ADDR_WIDTH-1:0]   read_adr,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    rd_valid,
   output logic                    init_busy,
   output logic                    err
);

   localparam int NB = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    init_busy_q, init_busy_d;
   logic                    err_q, err_d;
   logic                    rd1_vld_q, rd1_vld_d;
   logic [DATA_WIDTH-1:0]   rd1_dat_q, rd1_dat_d;
   logic                    rd2_vld_q, rd2_vld_d;
   logic [DATA_WIDTH-1:0]   rd2_dat_q, rd2_dat_d;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    acc_ok, wr_oor, rd_oor, wr_ok, rd_acc, rd_in;
   logic [DATA_WIDTH-1:0]   be_mask, rd_word, rd_merged, rd_sel;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_adr;
   logic [DATA_WIDTH-1:0]   mem_dat;
   logic [NB-1:0]           mem_be;

   always_comb begin
      acc_ok = (state_q == ST_READY) && !clr;
      wr_oor = ({1'b0, write_adr} >= DEPTH_W);
      rd_oor = ({1'b0, read_adr} >= DEPTH_W);
      wr_ok  = acc_ok && wr && !wr_oor;
      rd_acc = acc_ok && rd;
      rd_in  = rd_acc && !rd_oor;

      be_mask = '0;
      for (int i = 0; i < NB; i++) be_mask[8*i +: 8] = {8{wr_be[i]}};

      // Write-first returns the byte-merged word when both ports hit the same address.
      rd_word   = mem[read_adr];
      rd_merged = (rd_word & ~be_mask) | (data_in & be_mask);
      rd_sel    = (RDW_MODE == 0 && wr_ok && write_adr == read_adr) ? rd_merged : rd_word;

      if (state_q == ST_INIT) begin
         mem_we  = 1'b1;
         mem_adr = cnt_q;
         mem_dat = '0;
         mem_be  = '1;
      end else begin
         mem_we  = wr_ok;
         mem_adr = write_adr;
         mem_dat = data_in;
         mem_be  = wr_be;
      end

      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         if (cnt_q == LAST_ADR) begin
            state_d = ST_READY;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (clr) begin
         state_d = ST_INIT;
         cnt_d   = '0;
      end

      init_busy_d = (state_d == ST_INIT);
      err_d       = acc_ok && ((wr && wr_oor) || (rd && rd_oor));
      rd1_vld_d   = rd_acc;
      rd1_dat_d   = rd_acc ? (rd_in ? rd_sel : '0) : rd1_dat_q;
      // The second stage drains even across clr so an in-flight read still completes.
      rd2_vld_d   = rd1_vld_q;
      rd2_dat_d   = rd1_vld_q ? rd1_dat_q : rd2_dat_q;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) mem[mem_adr][8*i +: 8] <= mem_dat[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
         cnt_q       <= '0;
         init_busy_q <= (CLEAR_ON_RESET != 0);
         err_q       <= 1'b0;
         rd1_vld_q   <= 1'b0;
         rd1_dat_q   <= '0;
         rd2_vld_q   <= 1'b0;
         rd2_dat_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_busy_q <= init_busy_d;
         err_q       <= err_d;
         rd1_vld_q   <= rd1_vld_d;
         rd1_dat_q   <= rd1_dat_d;
         rd2_vld_q   <= rd2_vld_d;
         rd2_dat_q   <= rd2_dat_d;
      end
   end

   assign data_out  = (OUT_REG != 0) ? rd2_dat_q : rd1_dat_q;
   assign rd_valid  = (OUT_REG != 0) ? rd2_vld_q : rd1_vld_q;
   assign init_busy = init_busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dp_ram_param.sv
// Three RAM configurations driven by shared stimulus and checked every cycle
// against a word-array model, plus directed literal checks.
module tb_dp_ram_param;

   localparam int DEP  [3] = '{16, 16, 1000};
   localparam int RDW  [3] = '{0, 1, 0};
   localparam int OREG [3] = '{0, 1, 0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [9:0]  write_adr = '0, read_adr = '0;
   logic [63:0] data_in = '0;
   logic [7:0]  wr_be = '0;

   logic [63:0] dout  [3];
   logic        vld   [3];
   logic        busy  [3];
   logic        err_o [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dp_ram_param #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .DEPTH(16), .RDW_MODE(0), .OUT_REG(0),
                  .CLEAR_ON_RESET(1)) u0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .write_adr(write_adr[3:0]),
      .data_in(data_in), .wr_be(wr_be), .rd(rd), .read_adr(read_adr[3:0]),
      .data_out(dout[0]), .rd_valid(vld[0]), .init_busy(busy[0]), .err(err_o[0]));

   dp_ram_param #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .DEPTH(16), .RDW_MODE(1), .OUT_REG(1),
                  .CLEAR_ON_RESET(1)) u1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .write_adr(write_adr[3:0]),
      .data_in(data_in), .wr_be(wr_be), .rd(rd), .read_adr(read_adr[3:0]),
      .data_out(dout[1]), .rd_valid(vld[1]), .init_busy(busy[1]), .err(err_o[1]));

   dp_ram_param #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .DEPTH(1000), .RDW_MODE(0), .OUT_REG(0),
                  .CLEAR_ON_RESET(1)) u2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .write_adr(write_adr),
      .data_in(data_in), .wr_be(wr_be), .rd(rd), .read_adr(read_adr),
      .data_out(dout[2]), .rd_valid(vld[2]), .init_busy(busy[2]), .err(err_o[2]));

   // Reference model: word array per instance, a count of sweep edges left, and a
   // one-deep pending slot standing in for the extra output stage.
   logic [63:0] mm [3][1024];
   int          busy_left [3];
   logic        e_vld [3], e_err [3], p_vld [3];
   logic [63:0] e_dout [3], p_dat [3];
   logic        nv, win, rin;
   logic [63:0] nd, nw, mask;
   int          wa, ra;

   initial begin
      for (int k = 0; k < 3; k++)
         for (int a = 0; a < 1024; a++) mm[k][a] = '0;
   end

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            busy_left[k] = DEP[k];
            e_vld[k] = 1'b0; e_err[k] = 1'b0; e_dout[k] = '0;
            p_vld[k] = 1'b0; p_dat[k] = '0;
         end else begin
            nv = 1'b0; nd = '0; e_err[k] = 1'b0;
            if (busy_left[k] > 0) begin
               mm[k][DEP[k] - busy_left[k]] = '0;
               busy_left[k]--;
            end else if (clr) begin
               busy_left[k] = DEP[k];
            end else begin
               wa = (k == 2) ? int'(write_adr) : int'(write_adr[3:0]);
               ra = (k == 2) ? int'(read_adr)  : int'(read_adr[3:0]);
               win = wr && (wa < DEP[k]);
               rin = rd && (ra < DEP[k]);
               e_err[k] = (wr && wa >= DEP[k]) || (rd && ra >= DEP[k]);
               for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{wr_be[b]}};
               nw = (mm[k][wa] & ~mask) | (data_in & mask);
               if (rd) begin
                  nv = 1'b1;
                  if (!rin) nd = '0;
                  else if (RDW[k] == 0 && win && wa == ra) nd = nw;
                  else nd = mm[k][ra];
               end
               if (win) mm[k][wa] = nw;
            end
            if (OREG[k] != 0) begin
               e_vld[k] = p_vld[k];
               if (p_vld[k]) e_dout[k] = p_dat[k];
               p_vld[k] = nv;
               if (nv) p_dat[k] = nd;
            end else begin
               e_vld[k] = nv;
               if (nv) e_dout[k] = nd;
            end
         end
      end
   end

   task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s u%0d at %0t: got %h want %h", nm, k, $time, got, want);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk("busy", k, 64'(busy[k]), 64'(rst_n ? (busy_left[k] > 0) : 1'b1));
         chk("rd_valid", k, 64'(vld[k]), 64'(e_vld[k]));
         chk("err", k, 64'(err_o[k]), 64'(e_err[k]));
         chk("data_out", k, dout[k], e_dout[k]);
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      clr = 1'b0; wr = 1'b0; rd = 1'b0;
   endtask

   // Literal check of the sweep length: 16 edges for the small RAMs, 1000 for the large one.
   task automatic release_and_count();
      rst_n = 1'b1;
      repeat (15) cyc();
      chk("lit_busy15", 0, 64'(busy[0]), 64'd1);
      cyc();
      chk("lit_busy16", 0, 64'(busy[0]), 64'd0);
      chk("lit_busy16", 1, 64'(busy[1]), 64'd0);
      chk("lit_busy16", 2, 64'(busy[2]), 64'd1);
      repeat (983) cyc();
      chk("lit_busy999", 2, 64'(busy[2]), 64'd1);
      cyc();
      chk("lit_busy1000", 2, 64'(busy[2]), 64'd0);
   endtask

   function automatic logic [9:0] pick();
      int r;
      r = $urandom % 4;
      if (r == 0) return 10'(990 + $urandom % 34);
      if (r == 1) return 10'($urandom % 1024);
      return 10'($urandom % 32);
   endfunction

   initial begin
      repeat (3) cyc();
      chk("lit_rst_busy", 0, 64'(busy[0]), 64'd1);
      chk("lit_rst_vld", 0, 64'(vld[0]), 64'd0);
      chk("lit_rst_dout", 0, dout[0], 64'd0);
      release_and_count();

      // Fill with garbage, leave a nonzero word on data_out, then reset asynchronously.
      for (int a = 0; a < 16; a++) begin
         wr = 1'b1; wr_be = 8'hFF; write_adr = 10'(a); data_in = {$urandom, $urandom} | 64'h1;
         cyc();
      end
      idle(); rd = 1'b1; read_adr = 10'd3;
      cyc();
      idle();
      rst_n = 1'b0;
      #1;
      chk("lit_async_dout", 0, dout[0], 64'd0);
      chk("lit_async_busy", 0, 64'(busy[0]), 64'd1);
      cyc();
      rst_n = 1'b1;
      repeat (7) cyc();
      rst_n = 1'b0;
      cyc();
      chk("lit_mid_busy", 2, 64'(busy[2]), 64'd1);
      chk("lit_mid_vld", 0, 64'(vld[0]), 64'd0);
      release_and_count();

      for (int a = 0; a < 16; a++) begin
         rd = 1'b1; read_adr = 10'(a);
         cyc();
         chk("lit_clear_vld", 0, 64'(vld[0]), 64'd1);
         chk("lit_clear_dout", 0, dout[0], 64'd0);
      end
      idle();

      // Byte-enable merge.
      wr = 1'b1; write_adr = 10'd3; wr_be = 8'hFF; data_in = 64'h1122334455667788;
      cyc();
      wr_be = 8'h0F; data_in = 64'hAAAAAAAAAAAAAAAA;
      cyc();
      idle(); rd = 1'b1; read_adr = 10'd3;
      cyc();
      idle();
      chk("lit_be_merge", 0, dout[0], 64'h11223344AAAAAAAA);
      cyc();
      chk("lit_be_merge", 1, dout[1], 64'h11223344AAAAAAAA);

      // Same-address read and write: write-first vs read-first.
      wr = 1'b1; rd = 1'b1; write_adr = 10'd5; read_adr = 10'd5; wr_be = 8'hFF; data_in = '1;
      cyc();
      chk("lit_rdw_wf", 0, dout[0], '1);
      wr = 1'b0;
      cyc();
      chk("lit_rdw_rf", 1, dout[1], 64'd0);
      chk("lit_rdw_next", 0, dout[0], '1);
      idle();
      cyc();
      chk("lit_rdw_next", 1, dout[1], '1);

      // Both ports out of range on the large RAM.
      wr = 1'b1; rd = 1'b1; write_adr = 10'd1000; read_adr = 10'd1001; data_in = 64'h5A5A;
      cyc();
      chk("lit_oor_err", 2, 64'(err_o[2]), 64'd1);
      chk("lit_oor_vld", 2, 64'(vld[2]), 64'd1);
      chk("lit_oor_dout", 2, dout[2], 64'd0);
      idle();
      cyc();
      chk("lit_oor_pulse", 2, 64'(err_o[2]), 64'd0);

      // Two-cycle latency with back-to-back reads.
      rd = 1'b1; read_adr = 10'd0;
      cyc();
      chk("lit_oreg_v0", 1, 64'(vld[1]), 64'd0);
      read_adr = 10'd1;
      cyc();
      chk("lit_oreg_v1", 1, 64'(vld[1]), 64'd1);
      read_adr = 10'd2;
      cyc();
      chk("lit_oreg_v2", 1, 64'(vld[1]), 64'd1);
      idle();
      cyc();
      chk("lit_oreg_v3", 1, 64'(vld[1]), 64'd1);
      cyc();
      chk("lit_oreg_v4", 1, 64'(vld[1]), 64'd0);

      // clr outranks a simultaneous access.
      clr = 1'b1; wr = 1'b1; rd = 1'b1; write_adr = 10'd1010; read_adr = 10'd1010;
      cyc();
      idle();
      chk("lit_clr_err", 2, 64'(err_o[2]), 64'd0);
      chk("lit_clr_vld", 2, 64'(vld[2]), 64'd0);
      chk("lit_clr_busy", 0, 64'(busy[0]), 64'd1);
      repeat (1000) cyc();
      rd = 1'b1; read_adr = 10'd5;
      cyc();
      idle();
      chk("lit_clr_dout", 0, dout[0], 64'd0);

      for (int n = 0; n < 2500; n++) begin
         wr = 1'($urandom % 2);
         rd = 1'($urandom % 2);
         wr_be = 8'($urandom);
         data_in = {$urandom, $urandom};
         write_adr = pick();
         read_adr = ($urandom % 4 == 0) ? write_adr : pick();
         clr = ($urandom % 900 == 0);
         cyc();
      end
      idle();
      repeat (3) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dp_ram_param.md
# dp_ram_param

Parametrised simple dual-port RAM (one write port, one read port, one clock) for storage of operand/result words. It generalises the team's fixed 64x1024 memory with configurable width and depth and byte-enable writes. It adds a selectable read-during-write policy, an optional output register, and a self-clearing init state machine. Out-of-range accesses are flagged rather than aliased.

## Interface
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address width.
- DEPTH, 1024, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
- RDW_MODE, 0, same-address read/write policy: 0 = write-first (new data), 1 = read-first (old data).
- OUT_REG, 0, 0 = 1-cycle read latency, 1 = extra output register (2-cycle latency).
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = ready immediately.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- clr  in  1  request a full clear sweep (sampled only in READY).
- wr  in  1  write request.
- write_adr  in  ADDR_WIDTH  write address.
- data_in  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers data bits 8i+7:8i.
- rd  in  1  read request.
- read_adr  in  ADDR_WIDTH  read address.
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out carries the result of a read, one cycle per accepted read.
- init_busy  out  1  clear sweep in progress; accesses ignored.
- err  out  1  one-cycle pulse: an accepted access had address >= DEPTH.

## Operation
- FSM states: INIT, READY.
- Reset: state = INIT when CLEAR_ON_RESET = 1, otherwise READY. Sweep counter = 0. Outputs: data_out = 0, rd_valid = 0, err = 0, init_busy = CLEAR_ON_RESET. The output-register stage is cleared. Array contents are not reset asynchronously.
- INIT: each edge writes 0 to address counter and increments the counter. On the edge where counter == DEPTH-1, the FSM writes that last zero and moves to READY. rd, wr and clr are ignored; rd_valid and err stay 0.
- READY, clr = 1: next state INIT with counter = 0. rd and wr in that same cycle are ignored (clr has priority). A read already in the OUT_REG stage still completes.
- READY, wr = 1, write_adr < DEPTH: write only bytes with wr_be[i] = 1. Other bytes keep their value. wr_be = 0 is a legal no-op write.
- READY, rd = 1, read_adr < DEPTH: capture the word. With RDW_MODE 0 and wr to the same address in the same cycle, capture the byte-merged new word: enabled bytes from data_in, the rest old. With RDW_MODE 1, capture the pre-write word.
- Out of range: a write is dropped. A read still produces rd_valid with data_out = 0. err pulses once even if both ports are out of range.
- data_out holds its last value when there is no read; only rd_valid drops.

## Timing
- OUT_REG = 0: read sampled at edge N gives data_out and rd_valid valid after edge N.
- OUT_REG = 1: read sampled at edge N gives data_out and rd_valid valid after edge N+1.
- Back-to-back reads every cycle are allowed, giving full throughput.
- err is registered at the access edge, valid after edge N, and is not delayed by OUT_REG.
- init_busy stays high for exactly DEPTH rising edges after rst_n release (or after clr acceptance + 1). The first access is accepted on the edge after init_busy is seen low.
- Write visibility: a write at edge N is visible to a different-address read or a read-first read at edge N+1 or later.
- rst_n asserted mid-sweep or mid-read: outputs take reset values immediately. The sweep restarts at address 0 after release, and the pending read is discarded.

## Test plan
- DEPTH=16, CLEAR_ON_RESET=1, preload garbage via previous run: release rst_n -> init_busy high 16 edges. Reading addresses 0..15 then returns 0, with rd_valid one cycle after each rd (OUT_REG=0).
- wr 0x1122334455667788 to adr 3 with wr_be=0xFF, then wr 0xAAAAAAAAAAAAAAAA with wr_be=0x0F -> read adr 3 returns 0x11223344AAAAAAAA.
- Same-cycle rd/wr adr 5, old 0x0, new 0xFFFF..FF, wr_be=0xFF -> RDW_MODE 0 returns all-ones; RDW_MODE 1 returns 0. A following read returns all-ones in both modes.
- DEPTH=1000, ADDR_WIDTH=10: wr to 1000 and rd 1001 in the same cycle -> no array change, one err pulse, rd_valid=1 with data_out=0.
- OUT_REG=1, reads of adr 0,1,2 on consecutive edges -> data appears 2 cycles later, 3 consecutive rd_valid.
- Assert rst_n mid-sweep at counter 7 -> all outputs at reset values. After release, init_busy high for the full DEPTH again. clr in READY with wr asserted -> the write is dropped and the sweep runs.
